// File: rtl/axi4l2wb_bridge.sv
// AXI4-Lite responder that replays one transaction at a time as a pipelined Wishbone B4 cycle.
// Read/write contention alternates grants; a bounded wait turns a silent responder into DECERR.
module axi4l2wb_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [ADDR_WIDTH-1:0]   axi4l_awaddr,
  input  logic                    axi4l_awvalid,
  output logic                    axi4l_awready,
  input  logic [DATA_WIDTH-1:0]   axi4l_wdata,
  input  logic [DATA_WIDTH/8-1:0] axi4l_wstrb,
  input  logic                    axi4l_wvalid,
  output logic                    axi4l_wready,
  output logic [1:0]              axi4l_bresp,
  output logic                    axi4l_bvalid,
  input  logic                    axi4l_bready,
  input  logic [ADDR_WIDTH-1:0]   axi4l_araddr,
  input  logic                    axi4l_arvalid,
  output logic                    axi4l_arready,
  output logic [DATA_WIDTH-1:0]   axi4l_rdata,
  output logic [1:0]              axi4l_rresp,
  output logic                    axi4l_rvalid,
  input  logic                    axi4l_rready,
  output logic                    wb_cyc,
  output logic                    wb_stb,
  output logic                    wb_we,
  output logic [ADDR_WIDTH-1:0]   wb_adr,
  output logic [DATA_WIDTH/8-1:0] wb_sel,
  output logic [DATA_WIDTH-1:0]   wb_wdat,
  input  logic [DATA_WIDTH-1:0]   wb_rdat,
  input  logic                    wb_ack,
  input  logic                    wb_err,
  input  logic                    wb_stall
);

  localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WB_REQ  = 3'd1,
    WB_WAIT = 3'd2,
    WR_RESP = 3'd3,
    RD_RESP = 3'd4
  } state_t;

  state_t               state_r;
  state_t               state_nxt_s;
  logic                 last_wr_r;
  logic [CNT_WIDTH-1:0] cnt_r;
  logic                 wr_elig_s;
  logic                 rd_elig_s;
  logic                 grant_wr_s;
  logic                 grant_rd_s;
  logic                 term_s;
  logic                 timeout_s;
  logic [1:0]           resp_s;

  // Next-state, arbitration and termination decode
  always_comb begin
    state_nxt_s = state_r;
    wr_elig_s   = axi4l_awvalid && axi4l_wvalid;
    rd_elig_s   = axi4l_arvalid;
    grant_wr_s  = 1'b0;
    grant_rd_s  = 1'b0;
    term_s      = 1'b0;
    timeout_s   = 1'b0;
    case (state_r)
      IDLE: begin
        // last_wr_r clears on reset so a contended first grant goes to the write
        if (wr_elig_s && (!rd_elig_s || !last_wr_r)) begin
          grant_wr_s  = 1'b1;
          state_nxt_s = WB_REQ;
        end else if (rd_elig_s) begin
          grant_rd_s  = 1'b1;
          state_nxt_s = WB_REQ;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WB_REQ, WB_WAIT: begin
        term_s    = (wb_ack || wb_err) && ((state_r == WB_WAIT) || !wb_stall);
        timeout_s = !term_s && (cnt_r == CNT_WIDTH'(TIMEOUT_CYCLES - 1));
        if (term_s || timeout_s) begin
          state_nxt_s = wb_we ? WR_RESP : RD_RESP;
        end else if (!wb_stall) begin
          state_nxt_s = WB_WAIT;
        end else begin
          state_nxt_s = state_r;
        end
      end
      WR_RESP: begin
        if (axi4l_bready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WR_RESP;
        end
      end
      RD_RESP: begin
        if (axi4l_rready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RD_RESP;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
    resp_s = timeout_s ? 2'b11 : (wb_err ? 2'b10 : 2'b00);
  end

  assign axi4l_awready = grant_wr_s;
  assign axi4l_wready  = grant_wr_s;
  assign axi4l_arready = grant_rd_s;

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Wishbone request, timeout counter and AXI response registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      wb_cyc       <= 1'b0;
      wb_stb       <= 1'b0;
      wb_we        <= 1'b0;
      wb_adr       <= '0;
      wb_sel       <= '0;
      wb_wdat      <= '0;
      axi4l_bvalid <= 1'b0;
      axi4l_bresp  <= 2'b00;
      axi4l_rvalid <= 1'b0;
      axi4l_rresp  <= 2'b00;
      axi4l_rdata  <= '0;
      cnt_r        <= '0;
      last_wr_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_wr_s || grant_rd_s) begin
            wb_cyc    <= 1'b1;
            wb_stb    <= 1'b1;
            wb_we     <= grant_wr_s;
            wb_adr    <= grant_wr_s ? axi4l_awaddr : axi4l_araddr;
            wb_sel    <= grant_wr_s ? axi4l_wstrb : '1;
            wb_wdat   <= grant_wr_s ? axi4l_wdata : wb_wdat;
            last_wr_r <= grant_wr_s;
            cnt_r     <= '0;
          end
        end
        WB_REQ, WB_WAIT: begin
          if (term_s || timeout_s) begin
            wb_cyc <= 1'b0;
            wb_stb <= 1'b0;
            cnt_r  <= '0;
            if (wb_we) begin
              axi4l_bvalid <= 1'b1;
              axi4l_bresp  <= resp_s;
            end else begin
              axi4l_rvalid <= 1'b1;
              axi4l_rresp  <= resp_s;
              axi4l_rdata  <= timeout_s ? '0 : wb_rdat;
            end
          end else begin
            cnt_r <= cnt_r + CNT_WIDTH'(1);
            if (!wb_stall) begin
              wb_stb <= 1'b0;
            end
          end
        end
        WR_RESP: begin
          if (axi4l_bready) begin
            axi4l_bvalid <= 1'b0;
          end
        end
        RD_RESP: begin
          if (axi4l_rready) begin
            axi4l_rvalid <= 1'b0;
          end
        end
        default: begin
          wb_cyc <= 1'b0;
          wb_stb <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi4l2wb_bridge.sv
// Randomized bench for axi4l2wb_bridge: a per-transaction timing model predicts every output cycle by cycle.
module tb_axi4l2wb_bridge;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst;
  logic [AW-1:0] axi4l_awaddr, axi4l_araddr, wb_adr;
  logic [DW-1:0] axi4l_wdata, axi4l_rdata, wb_wdat, wb_rdat;
  logic [SW-1:0] axi4l_wstrb, wb_sel;
  logic [1:0]    axi4l_bresp, axi4l_rresp;
  logic axi4l_awvalid, axi4l_awready, axi4l_wvalid, axi4l_wready, axi4l_bvalid, axi4l_bready;
  logic axi4l_arvalid, axi4l_arready, axi4l_rvalid, axi4l_rready;
  logic wb_cyc, wb_stb, wb_we, wb_ack, wb_err, wb_stall;

  always #5 clk = ~clk;

  axi4l2wb_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .CLK(clk), .RST(rst),
    .axi4l_awaddr(axi4l_awaddr), .axi4l_awvalid(axi4l_awvalid), .axi4l_awready(axi4l_awready),
    .axi4l_wdata(axi4l_wdata), .axi4l_wstrb(axi4l_wstrb), .axi4l_wvalid(axi4l_wvalid), .axi4l_wready(axi4l_wready),
    .axi4l_bresp(axi4l_bresp), .axi4l_bvalid(axi4l_bvalid), .axi4l_bready(axi4l_bready),
    .axi4l_araddr(axi4l_araddr), .axi4l_arvalid(axi4l_arvalid), .axi4l_arready(axi4l_arready),
    .axi4l_rdata(axi4l_rdata), .axi4l_rresp(axi4l_rresp), .axi4l_rvalid(axi4l_rvalid), .axi4l_rready(axi4l_rready),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr), .wb_sel(wb_sel), .wb_wdat(wb_wdat),
    .wb_rdat(wb_rdat), .wb_ack(wb_ack), .wb_err(wb_err), .wb_stall(wb_stall)
  );

  // kind: 0 ack, 1 err, 2 never terminates, 3 ack and err together
  typedef struct { int stall_n; int dly; int kind; logic [DW-1:0] rdat; } plan_t;
  plan_t plans[$];

  int n_checks = 0;
  int n_errors = 0;
  int rdy_dly = 0;
  bit glitch = 1'b0;
  int n_done = 0;
  int obs_stb, obs_cyc, obs_vld;
  logic obs_we;
  logic [SW-1:0] obs_sel;
  logic [AW-1:0] obs_adr;
  logic [1:0] obs_resp;
  logic [DW-1:0] obs_rdata;
  logic done_we[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic plan_t get_plan(input int idx);
    plan_t p;
    p.stall_n = 0; p.dly = 0; p.kind = 0; p.rdat = '0;
    if (idx < plans.size()) p = plans[idx];
    return p;
  endfunction

  task automatic push_plan(input int s, input int d, input int k, input logic [DW-1:0] r);
    plan_t p;
    p.stall_n = s; p.dly = d; p.kind = k; p.rdat = r;
    plans.push_back(p);
  endtask

  // Wishbone responder: stalls, then terminates after a delay, as the next plan says
  initial begin : responder
    plan_t cur;
    bit active;
    int st, dl, rs_idx;
    active = 1'b0; rs_idx = 0; st = 0; dl = 0;
    wb_ack = 1'b0; wb_err = 1'b0; wb_stall = 1'b0; wb_rdat = '0;
    forever begin
      @(negedge clk);
      wb_ack = 1'b0; wb_err = 1'b0; wb_stall = 1'b0;
      if (wb_cyc && !rst) begin
        if (!active) begin
          active = 1'b1; cur = get_plan(rs_idx); rs_idx++;
          st = cur.stall_n; dl = cur.dly;
        end
        wb_rdat = cur.rdat;
        if (st > 0) begin
          wb_stall = 1'b1; st--;
        end else if (dl > 0) begin
          dl--;
        end else begin
          wb_ack = (cur.kind == 0) || (cur.kind == 3);
          wb_err = (cur.kind == 1) || (cur.kind == 3);
        end
      end else begin
        active = 1'b0;
        wb_ack = glitch;
        wb_rdat = $urandom;
      end
    end
  end

  // AXI response consumer: ready rises rdy_dly cycles after valid is seen
  initial begin : consumer
    int bw, rw;
    bw = 0; rw = 0; axi4l_bready = 1'b0; axi4l_rready = 1'b0;
    forever begin
      @(negedge clk);
      if (axi4l_bvalid === 1'b1 && !rst) begin
        if (bw >= rdy_dly) axi4l_bready = 1'b1; else begin axi4l_bready = 1'b0; bw++; end
      end else begin
        axi4l_bready = 1'b0; bw = 0;
      end
      if (axi4l_rvalid === 1'b1 && !rst) begin
        if (rw >= rdy_dly) axi4l_rready = 1'b1; else begin axi4l_rready = 1'b0; rw++; end
      end else begin
        axi4l_rready = 1'b0; rw = 0;
      end
    end
  end

  // Reference model and compare: each transaction is a timeline measured in cycles since its grant
  initial begin : model
    plan_t p;
    bit m_busy, m_last_wr, m_just_reset, m_we, g_wr, g_rd, hs;
    int m_age, m_c, m_s, ck_idx;
    logic [AW-1:0] m_adr;
    logic [SW-1:0] m_sel;
    logic [DW-1:0] m_wdat, m_rdata;
    logic [1:0] m_resp;
    m_busy = 1'b0; m_last_wr = 1'b0; m_just_reset = 1'b0; m_age = 0; m_c = 0; m_s = 0; ck_idx = 0;
    forever begin
      @(negedge clk); #2;
      if (rst) begin
        m_busy = 1'b0; m_last_wr = 1'b0; m_just_reset = 1'b1;
      end else if (m_busy) begin
        m_age++;
        chk("awready_busy", axi4l_awready, 1'b0);
        chk("wready_busy", axi4l_wready, 1'b0);
        chk("arready_busy", axi4l_arready, 1'b0);
        chk("cyc", wb_cyc, m_age <= m_c);
        chk("stb", wb_stb, m_age <= m_s);
        chk("bvalid", axi4l_bvalid, m_we && (m_age > m_c));
        chk("rvalid", axi4l_rvalid, !m_we && (m_age > m_c));
        if (m_age <= m_c) begin
          chk("wb_we", wb_we, m_we);
          chk("wb_adr", wb_adr, m_adr);
          chk("wb_sel", wb_sel, m_sel);
          if (m_we) chk("wb_wdat", wb_wdat, m_wdat);
        end
        if (wb_stb === 1'b1) begin
          obs_stb++; obs_we = wb_we; obs_sel = wb_sel; obs_adr = wb_adr;
        end
        if (wb_cyc === 1'b1) obs_cyc++;
        if (m_age > m_c) begin
          if (m_we) begin
            chk("bresp", axi4l_bresp, m_resp);
          end else begin
            chk("rresp", axi4l_rresp, m_resp);
            chk("rdata", axi4l_rdata, m_rdata);
          end
          if (axi4l_bvalid === 1'b1 || axi4l_rvalid === 1'b1) obs_vld++;
          hs = m_we ? axi4l_bready : axi4l_rready;
          if (hs) begin
            obs_resp = m_we ? axi4l_bresp : axi4l_rresp;
            obs_rdata = axi4l_rdata;
            done_we.push_back(obs_we);
            n_done++;
            m_busy = 1'b0;
          end
        end
      end else begin
        chk("cyc_idle", wb_cyc, 1'b0);
        chk("stb_idle", wb_stb, 1'b0);
        chk("bvalid_idle", axi4l_bvalid, 1'b0);
        chk("rvalid_idle", axi4l_rvalid, 1'b0);
        if (m_just_reset) begin
          chk("rst_we", wb_we, 1'b0);
          chk("rst_bresp", axi4l_bresp, 2'b00);
          chk("rst_rresp", axi4l_rresp, 2'b00);
          chk("rst_rdata", axi4l_rdata, '0);
          m_just_reset = 1'b0;
        end
        g_wr = axi4l_awvalid && axi4l_wvalid && (!axi4l_arvalid || !m_last_wr);
        g_rd = axi4l_arvalid && !g_wr;
        chk("awready", axi4l_awready, g_wr);
        chk("wready", axi4l_wready, g_wr);
        chk("arready", axi4l_arready, g_rd);
        if (g_wr || g_rd) begin
          m_we = g_wr;
          m_adr = g_wr ? axi4l_awaddr : axi4l_araddr;
          m_sel = g_wr ? axi4l_wstrb : {SW{1'b1}};
          m_wdat = axi4l_wdata;
          p = get_plan(ck_idx); ck_idx++;
          if (p.kind == 2 || p.stall_n + p.dly + 1 > TO) begin
            m_c = TO; m_resp = 2'b11; m_rdata = '0;
          end else begin
            m_c = p.stall_n + p.dly + 1; m_resp = (p.kind == 0) ? 2'b00 : 2'b10; m_rdata = p.rdat;
          end
          m_s = (p.stall_n + 1 < m_c) ? p.stall_n + 1 : m_c;
          m_last_wr = g_wr; m_busy = 1'b1; m_age = 0;
          obs_stb = 0; obs_cyc = 0; obs_vld = 0;
        end
      end
    end
  end

  task automatic send_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    axi4l_awaddr = a; axi4l_wdata = d; axi4l_wstrb = s; axi4l_awvalid = 1'b1; axi4l_wvalid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      #1;
      if (axi4l_awready === 1'b1 && axi4l_wready === 1'b1) ok = 1'b1;
      @(negedge clk);
    end
    axi4l_awvalid = 1'b0; axi4l_wvalid = 1'b0;
    if (!ok) chk("wr_handshake_timeout", 1'b0, 1'b1);
  endtask

  task automatic send_rd(input logic [AW-1:0] a);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    axi4l_araddr = a; axi4l_arvalid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      #1;
      if (axi4l_arready === 1'b1) ok = 1'b1;
      @(negedge clk);
    end
    axi4l_arvalid = 1'b0;
    if (!ok) chk("rd_handshake_timeout", 1'b0, 1'b1);
  endtask

  task automatic wait_done(input int tgt);
    for (int i = 0; i < 300 && n_done < tgt; i++) @(negedge clk);
    if (n_done < tgt) chk("response_timeout", n_done, tgt);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : seq
    int tgt, n0, sel_t;
    rst = 1'b1;
    axi4l_awaddr = '0; axi4l_wdata = '0; axi4l_wstrb = '0; axi4l_awvalid = 1'b0; axi4l_wvalid = 1'b0;
    axi4l_araddr = '0; axi4l_arvalid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #3;
    chk("reset_cyc", wb_cyc, 1'b0);
    chk("reset_bvalid", axi4l_bvalid, 1'b0);
    chk("reset_rdata", axi4l_rdata, 32'h0);

    // single write, ack one cycle after acceptance
    push_plan(0, 1, 0, 32'h0);
    tgt = n_done + 1; send_wr(32'h10, 32'hDEADBEEF, 4'hF); wait_done(tgt);
    chk("w1_stb_cycles", obs_stb, 1);
    chk("w1_we", obs_we, 1'b1);
    chk("w1_sel", obs_sel, 4'hF);
    chk("w1_adr", obs_adr, 32'h10);
    chk("w1_bresp", obs_resp, 2'b00);
    chk("w1_cyc_cycles", obs_cyc, 2);
    chk("w1_bvalid_cycles", obs_vld, 1);

    // read stalled three cycles
    push_plan(3, 1, 0, 32'hA5A5A5A5);
    tgt = n_done + 1; send_rd(32'h24); wait_done(tgt);
    chk("r1_stb_cycles", obs_stb, 4);
    chk("r1_rdata", obs_rdata, 32'hA5A5A5A5);
    chk("r1_rresp", obs_resp, 2'b00);
    chk("r1_sel", obs_sel, 4'hF);

    // simultaneous write+read twice after reset: write, read, write, read
    do_reset();
    repeat (4) push_plan(0, 0, 0, 32'h13579BDF);
    n0 = done_we.size();
    for (int k = 0; k < 2; k++) begin
      tgt = n_done + 2;
      fork
        send_wr(32'h100 + k, 32'h11111111, 4'hF);
        send_rd(32'h200 + k);
      join
      wait_done(tgt);
    end
    if (done_we.size() >= n0 + 4) begin
      chk("arb_0", done_we[n0], 1'b1);
      chk("arb_1", done_we[n0+1], 1'b0);
      chk("arb_2", done_we[n0+2], 1'b1);
      chk("arb_3", done_we[n0+3], 1'b0);
    end else begin
      chk("arb_count", done_we.size(), n0 + 4);
    end

    // err on write, silent responder on read
    push_plan(0, 0, 1, 32'h0);
    tgt = n_done + 1; send_wr(32'h30, 32'h12345678, 4'h3); wait_done(tgt);
    chk("err_bresp", obs_resp, 2'b10);
    push_plan(0, 0, 2, 32'h5A5A5A5A);
    tgt = n_done + 1; send_rd(32'h40); wait_done(tgt);
    chk("to_rresp", obs_resp, 2'b11);
    chk("to_rdata", obs_rdata, 32'h0);
    chk("to_cyc_cycles", obs_cyc, 8);

    // rready held off five cycles, then an ack while idle
    rdy_dly = 5;
    push_plan(0, 1, 0, 32'hCAFEF00D);
    tgt = n_done + 1; send_rd(32'h50); wait_done(tgt);
    chk("hold_rvalid_cycles", obs_vld, 6);
    chk("hold_rdata", obs_rdata, 32'hCAFEF00D);
    rdy_dly = 0;
    @(negedge clk); glitch = 1'b1;
    repeat (3) @(negedge clk);
    glitch = 1'b0; #3;
    chk("glitch_cyc", wb_cyc, 1'b0);
    chk("glitch_rvalid", axi4l_rvalid, 1'b0);
    chk("glitch_bvalid", axi4l_bvalid, 1'b0);

    // reset pulse while waiting for termination, then a normal write
    push_plan(0, 6, 0, 32'h0);
    send_wr(32'h60, 32'h0BADF00D, 4'hF);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; #3;
    chk("midrst_cyc", wb_cyc, 1'b0);
    chk("midrst_stb", wb_stb, 1'b0);
    chk("midrst_bvalid", axi4l_bvalid, 1'b0);
    chk("midrst_bresp", axi4l_bresp, 2'b00);
    push_plan(0, 1, 0, 32'h0);
    tgt = n_done + 1; send_wr(32'h70, 32'hA0A0A0A0, 4'hF); wait_done(tgt);
    chk("postrst_bresp", obs_resp, 2'b00);
    chk("postrst_adr", obs_adr, 32'h70);

    // randomized traffic
    for (int it = 0; it < 40; it++) begin
      sel_t = $urandom_range(2, 0);
      rdy_dly = $urandom_range(3, 0);
      repeat ((sel_t == 2) ? 2 : 1)
        push_plan($urandom_range(4, 0), $urandom_range(4, 0), $urandom_range(3, 0), $urandom);
      tgt = n_done + ((sel_t == 2) ? 2 : 1);
      case (sel_t)
        0: send_wr($urandom, $urandom, 4'($urandom_range(15, 0)));
        1: send_rd($urandom);
        default: begin
          fork
            send_wr($urandom, $urandom, 4'($urandom_range(15, 0)));
            send_rd($urandom);
          join
        end
      endcase
      wait_done(tgt);
    end
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
